program_sequencer: RTL and testbench

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/program_sequencer.sv | 107 ++++++++++
 tb/tb_program_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// Program counter with a LIFO return stack for call/ret.
// Define PROGRAM_SEQUENCER_ERR_EN for sticky overflow/underflow flags on err.
module program_sequencer #(
  parameter int              WIDTH       = 15,
  parameter int              DEPTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inc,
  input  logic                       load,
  input  logic                       call,
  input  logic                       ret,
  input  logic [WIDTH-1:0]           in,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty,
  output logic [1:0]                 err
);

  localparam int DW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [DW-1:0] DMAX = DW'(DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [DW-1:0]    dep_q, dep_d;
  logic [WIDTH-1:0] stk_q [DEPTH];
  logic [WIDTH-1:0] pc_inc;
  logic [DW-1:0]    top_idx;
  logic             is_full, is_empty;
  logic             push;

  assign pc_inc   = pc_q + WIDTH'(1);
  assign top_idx  = dep_q - DW'(1);
  assign is_full  = (dep_q == DMAX);
  assign is_empty = (dep_q == '0);

  // Next-state selection; call outranks ret, ret outranks load/inc.
  always_comb begin
    pc_d  = pc_q;
    dep_d = dep_q;
    push  = 1'b0;
    priority case (1'b1)
      rst: begin
        pc_d  = RESET_VALUE;
        dep_d = '0;
      end
      call: begin
        pc_d = in;
        if (!is_full) begin
          push  = 1'b1;
          dep_d = dep_q + DW'(1);
        end
      end
      ret: begin
        if (!is_empty) begin
          pc_d  = stk_q[top_idx[AW-1:0]];
          dep_d = top_idx;
        end
      end
      load:    pc_d = in;
      inc:     pc_d = pc_inc;
      default: ;
    endcase
  end

  // PC and stack occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VALUE;
      dep_q <= '0;
    end else begin
      pc_q  <= pc_d;
      dep_q <= dep_d;
    end
  end

  // Stack storage is not reset; depth alone defines valid entries.
  always_ff @(posedge clk) begin
    if (push) stk_q[dep_q[AW-1:0]] <= pc_inc;
  end

`ifdef PROGRAM_SEQUENCER_ERR_EN
  logic [1:0] err_q;
  logic       ovf, unf;

  assign ovf = call & is_full;
  assign unf = ~call & ret & is_empty;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_q | {unf, ovf};
  end

  assign err = err_q;
`else
  assign err = 2'b00;
`endif

  assign out   = pc_q;
  assign depth = dep_q;
  assign full  = is_full;
  assign empty = is_empty;

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer (WIDTH=15, DEPTH=4).
module tb_program_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inc = 1'b0;
  logic        load = 1'b0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [14:0] in = '0;
  logic [14:0] out;
  logic [2:0]  depth;
  logic        full, empty;
  logic [1:0]  err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic [14:0] o;
    int          d;
    logic [1:0]  e;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  program_sequencer #(
    .WIDTH(15), .DEPTH(4), .RESET_VALUE(15'h0000)
  ) dut (
    .clk(clk), .rst(rst), .inc(inc), .load(load),
    .call(call), .ret(ret), .in(in), .out(out),
    .depth(depth), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] eerr(input logic [1:0] v);
`ifdef PROGRAM_SEQUENCER_ERR_EN
    return v;
`else
    return 2'b00;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive one operation and queue the expected post-edge state.
  task automatic op(input string nm,
                    input logic r, i, l, c, t,
                    input logic [14:0] v,
                    input logic [14:0] eo,
                    input int ed,
                    input logic [1:0] ee);
    exp_t x;
    @(negedge clk);
    rst = r; inc = i; load = l; call = c; ret = t; in = v;
    x.nm = nm; x.o = eo; x.d = ed; x.e = eerr(ee);
    q.push_back(x);
  endtask

  // Monitor: one result per edge while expectations are pending.
  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      cur = q.pop_front();
      chk({cur.nm, ".out"},   int'(out),   int'(cur.o));
      chk({cur.nm, ".depth"}, int'(depth), cur.d);
      chk({cur.nm, ".full"},  int'(full),  int'(cur.d == 4));
      chk({cur.nm, ".empty"}, int'(empty), int'(cur.d == 0));
      chk({cur.nm, ".err"},   int'(err),   int'(cur.e));
    end
  end

  initial begin
    //      name      rst inc ld cal ret in        out       d  err
    op("rst",        1, 1, 0, 0, 0, 15'h2bcd, 15'h0000, 0, 2'b00);
    op("ld2bcd",     0, 0, 1, 0, 0, 15'h2bcd, 15'h2bcd, 0, 2'b00);
    op("inc1",       0, 1, 0, 0, 0, 15'h0000, 15'h2bce, 0, 2'b00);
    op("inc2",       0, 1, 0, 0, 0, 15'h0000, 15'h2bcf, 0, 2'b00);
    op("ld7fff",     0, 0, 1, 0, 0, 15'h7fff, 15'h7fff, 0, 2'b00);
    op("wrap",       0, 1, 0, 0, 0, 15'h0000, 15'h0000, 0, 2'b00);
    op("ld0010",     0, 0, 1, 0, 0, 15'h0010, 15'h0010, 0, 2'b00);
    op("call100",    0, 0, 0, 1, 0, 15'h0100, 15'h0100, 1, 2'b00);
    op("call200",    0, 0, 0, 1, 0, 15'h0200, 15'h0200, 2, 2'b00);
    op("ret1",       0, 0, 0, 0, 1, 15'h0000, 15'h0101, 1, 2'b00);
    op("ret2",       0, 0, 0, 0, 1, 15'h0000, 15'h0011, 0, 2'b00);
    op("ld0000",     0, 0, 1, 0, 0, 15'h0000, 15'h0000, 0, 2'b00);
    op("c1000",      0, 0, 0, 1, 0, 15'h1000, 15'h1000, 1, 2'b00);
    op("c1001",      0, 0, 0, 1, 0, 15'h1001, 15'h1001, 2, 2'b00);
    op("c1002",      0, 0, 0, 1, 0, 15'h1002, 15'h1002, 3, 2'b00);
    op("c1003",      0, 0, 0, 1, 0, 15'h1003, 15'h1003, 4, 2'b00);
    op("c1004ovf",   0, 1, 1, 1, 0, 15'h1004, 15'h1004, 4, 2'b01);
    op("r1003",      0, 0, 0, 0, 1, 15'h0000, 15'h1003, 3, 2'b01);
    op("r1002",      0, 0, 0, 0, 1, 15'h0000, 15'h1002, 2, 2'b01);
    op("r1001",      0, 0, 0, 0, 1, 15'h0000, 15'h1001, 1, 2'b01);
    op("r0001",      0, 0, 0, 0, 1, 15'h0000, 15'h0001, 0, 2'b01);
    op("rst2",       1, 0, 0, 0, 0, 15'h0000, 15'h0000, 0, 2'b00);
    op("ld0050",     0, 0, 1, 0, 0, 15'h0050, 15'h0050, 0, 2'b00);
    op("retunf",     0, 0, 0, 0, 1, 15'h0000, 15'h0050, 0, 2'b10);
    op("callret",    0, 0, 0, 1, 1, 15'h0300, 15'h0300, 1, 2'b10);
    op("hold",       0, 0, 0, 0, 0, 15'h0555, 15'h0300, 1, 2'b10);
    op("rstcall",    1, 0, 0, 1, 0, 15'h0400, 15'h0000, 0, 2'b00);
    op("retpost",    0, 0, 0, 0, 1, 15'h0000, 15'h0000, 0, 2'b10);
    op("retld",      0, 1, 1, 0, 1, 15'h1234, 15'h0000, 0, 2'b10);
    op("ldafter",    0, 0, 1, 0, 0, 15'h1234, 15'h1234, 0, 2'b10);
    op("rst3",       1, 0, 0, 0, 0, 15'h0000, 15'h0000, 0, 2'b00);
    @(negedge clk);
    rst = 0; inc = 0; load = 0; call = 0; ret = 0;
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
